// File: rtl/aud_pkg.sv
// Shared definitions for the audio recorder capture path.
//   rec_state_e : recorder run state, encoded as reported on o_state
//   AUD_DATA_W  : codec sample width (also the SRAM word width)
//   SRAM_ADDR_W : SRAM word address width
package aud_pkg;

  localparam int AUD_DATA_W  = 16;
  localparam int SRAM_ADDR_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } rec_state_e;

endpackage

// File: rtl/i2s_rx_deser.sv
// I2S left-channel deserialiser for the WM8731 ADC interface.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   en            : capture enable; low discards any partial word and realigns
//   bclk, lrck    : codec bit clock and LR clock (asynchronous to clk)
//   adcdat        : codec ADC serial data
//   o_sample      : completed left sample, valid while o_sample_stb is high
//   o_sample_stb  : one-cycle strobe on the clk cycle the LSB edge is detected
module i2s_rx_deser
  import aud_pkg::*;
#(
  parameter int W = AUD_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         bclk,
  input  logic         lrck,
  input  logic         adcdat,
  output logic [W-1:0] o_sample,
  output logic         o_sample_stb
);

  localparam int CNT_W = $clog2(W);

  logic [1:0]       bclk_sync;
  logic [1:0]       lrck_sync;
  logic [1:0]       dat_sync;
  logic             bclk_d;
  logic             lrck_prev;
  logic             active;
  logic [CNT_W-1:0] bit_cnt;
  logic [W-2:0]     shift;
  logic             rise;
  logic             lrck_fall;
  logic             last_bit;

  // The strobe and the completed word are combinational so the holding
  // register in the top loads on the same edge that shifts the LSB in.
  always_comb begin
    rise         = bclk_sync[1] & ~bclk_d;
    lrck_fall    = lrck_prev & ~lrck_sync[1];
    last_bit     = (bit_cnt == CNT_W'(W - 1));
    o_sample     = {shift, dat_sync[1]};
    o_sample_stb = rise & en & active & last_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_d    <= 1'b0;
      lrck_prev <= 1'b0;
      active    <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], lrck};
      dat_sync  <= {dat_sync[0], adcdat};
      bclk_d    <= bclk_sync[1];

      // LRCK history is tracked even when disabled so that a fall on the
      // very first edge after enabling is still recognised.
      if (rise) begin
        lrck_prev <= lrck_sync[1];
      end

      if (!en) begin
        active  <= 1'b0;
        bit_cnt <= '0;
        shift   <= '0;
      end else if (rise) begin
        if (active) begin
          shift   <= {shift[W-3:0], dat_sync[1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            active <= 1'b0;
          end
        end
        // The edge that sees LRCK fall carries no left data; the MSB follows.
        if (lrck_fall) begin
          active  <= 1'b1;
          bit_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// Audio recorder capture stage: I2S left channel to SRAM write port.
// Ports:
//   i_clk, i_rst                 : system clock, asynchronous active-high reset
//   i_start, i_pause, i_stop     : run-control pulses (stop > pause > start)
//   i_aud_bclk/lrck/adcdat       : codec ADC serial interface
//   o_wr_valid, i_wr_ready       : write handshake
//   o_wr_addr, o_wr_data         : held write address and sample
//   o_last_addr                  : address of the most recently accepted write
//   o_state                      : IDLE=0, REC=1, PAUSE=2, DONE=3
//   o_full, o_overflow           : last address written / sample dropped (sticky)
module aud_recorder
  import aud_pkg::*;
#(
  parameter int                DATA_W   = AUD_DATA_W,
  parameter int                ADDR_W   = SRAM_ADDR_W,
  parameter logic [ADDR_W-1:0] ADDR_MAX = '1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_aud_bclk,
  input  logic              i_aud_lrck,
  input  logic              i_aud_adcdat,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [ADDR_W-1:0] o_last_addr,
  output logic [1:0]        o_state,
  output logic              o_full,
  output logic              o_overflow
);

  rec_state_e        state;
  logic              capture_en;
  logic [DATA_W-1:0] sample;
  logic              sample_stb;
  logic              accept;
  logic              at_max;
  logic              pend;
  logic [DATA_W-1:0] pend_data;

  always_comb begin
    capture_en = (state == REC);
    accept     = o_wr_valid & i_wr_ready;
    at_max     = (o_wr_addr == ADDR_MAX);
    o_state    = state;
  end

  i2s_rx_deser #(
    .W (DATA_W)
  ) u_deser (
    .clk          (i_clk),
    .rst          (i_rst),
    .en           (capture_en),
    .bclk         (i_aud_bclk),
    .lrck         (i_aud_lrck),
    .adcdat       (i_aud_adcdat),
    .o_sample     (sample),
    .o_sample_stb (sample_stb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_last_addr <= '0;
      o_full      <= 1'b0;
      o_overflow  <= 1'b0;
      pend        <= 1'b0;
      pend_data   <= '0;
    end else begin
      if (accept) begin
        o_last_addr <= o_wr_addr;
        o_wr_valid  <= 1'b0;
        if (at_max) begin
          o_full <= 1'b1;
        end else begin
          o_wr_addr <= o_wr_addr + 1'b1;
        end
      end

      // A sample completing on the acceptance cycle is parked for one
      // cycle so the address has advanced before it is presented.
      if (pend) begin
        o_wr_valid <= 1'b1;
        o_wr_data  <= pend_data;
        pend       <= 1'b0;
      end

      if (sample_stb) begin
        if (!o_wr_valid && !pend) begin
          o_wr_valid <= 1'b1;
          o_wr_data  <= sample;
        end else if (accept) begin
          pend      <= 1'b1;
          pend_data <= sample;
        end else begin
          o_overflow <= 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state       <= REC;
            o_wr_valid  <= 1'b0;
            o_wr_addr   <= '0;
            o_last_addr <= '0;
            o_full      <= 1'b0;
            o_overflow  <= 1'b0;
            pend        <= 1'b0;
          end
        end
        REC: begin
          if (accept && at_max) begin
            state <= DONE;
            pend  <= 1'b0;
          end else if (i_stop) begin
            state <= DONE;
          end else if (i_pause) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (accept && at_max) begin
            state <= DONE;
          end else if (i_stop) begin
            state <= DONE;
          end else if (i_start) begin
            state <= REC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: drives a bit-level I2S stream and run-control
// pulses, and checks every accepted write against an ordered list of
// expected (address, sample) pairs built from the samples sent.
module tb_aud_recorder;

  localparam int P_START   = 0;
  localparam int P_PAUSE   = 1;
  localparam int P_STOP    = 2;
  localparam int P_F_START = 3;

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0, f_start = 1'b0;
  logic        bclk = 1'b0, lrck = 1'b1, adcdat = 1'b0;
  logic        ready = 1'b0;

  logic        wr_valid, full, overflow;
  logic [19:0] wr_addr, last_addr;
  logic [15:0] wr_data;
  logic [1:0]  state;

  logic        f_valid, f_full, f_overflow;
  logic [19:0] f_addr, f_last;
  logic [15:0] f_data;
  logic [1:0]  f_state;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int unsigned lsb_cyc = 0;
  logic        chk_lat = 1'b0;
  logic        prev_valid = 1'b0;
  logic [19:0] nxt_addr = '0;
  wr_t         exp_q[$];
  wr_t         f_q[$];

  aud_recorder dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pause      (pause),
    .i_stop       (stop),
    .i_aud_bclk   (bclk),
    .i_aud_lrck   (lrck),
    .i_aud_adcdat (adcdat),
    .o_wr_valid   (wr_valid),
    .i_wr_ready   (ready),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_last_addr  (last_addr),
    .o_state      (state),
    .o_full       (full),
    .o_overflow   (overflow)
  );

  aud_recorder #(
    .ADDR_MAX (20'h00003)
  ) dut_full (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (f_start),
    .i_pause      (1'b0),
    .i_stop       (1'b0),
    .i_aud_bclk   (bclk),
    .i_aud_lrck   (lrck),
    .i_aud_adcdat (adcdat),
    .o_wr_valid   (f_valid),
    .i_wr_ready   (ready),
    .o_wr_addr    (f_addr),
    .o_wr_data    (f_data),
    .o_last_addr  (f_last),
    .o_state      (f_state),
    .o_full       (f_full),
    .o_overflow   (f_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every accepted write must be the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (chk_lat && wr_valid && !prev_valid)
        check("latency", cyc - lsb_cyc, 32'd3);
      if (wr_valid && ready) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e.a));
          check("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (f_valid && ready) begin
        check("f_write_expected", 32'(f_q.size() != 0), 32'd1);
        if (f_q.size() != 0) begin
          e = f_q.pop_front();
          check("f_wr_addr", 32'(f_addr), 32'(e.a));
          check("f_wr_data", 32'(f_data), 32'(e.d));
        end
      end
    end
    prev_valid = wr_valid;
  end

  task automatic push_exp(input logic [15:0] d);
    exp_q.push_back('{a: nxt_addr, d: d});
    nxt_addr = nxt_addr + 20'd1;
  endtask

  // One BCLK period of 8 clk cycles; data and LRCK change while BCLK is low.
  task automatic bit_out(input logic lr, input logic d, input logic mark_lsb);
    lrck   = lr;
    adcdat = d;
    repeat (4) @(posedge clk);
    #1 bclk = 1'b1;
    if (mark_lsb) lsb_cyc = cyc;
    repeat (4) @(posedge clk);
    #1 bclk = 1'b0;
  endtask

  // Bit slots k of a 32-slot I2S frame: slot 0 sees LRCK low first,
  // slots 1..16 carry left[15:0], the remainder carry the right channel.
  task automatic send_bits(input logic [15:0] l, input logic [15:0] r,
                           input int from, input int to);
    for (int k = from; k <= to; k++) begin
      logic lr, d;
      if (k == 0) begin
        lr = 1'b0;
        d  = r[0];
      end else if (k <= 16) begin
        lr = (k == 16);
        d  = l[16-k];
      end else begin
        lr = 1'b1;
        d  = r[32-k];
      end
      bit_out(lr, d, k == 16);
    end
  endtask

  task automatic frame(input logic [15:0] l);
    send_bits(l, 16'($urandom), 0, 31);
  endtask

  task automatic pulse(input int which);
    @(posedge clk); #1;
    case (which)
      P_START:   start   = 1'b1;
      P_PAUSE:   pause   = 1'b1;
      P_STOP:    stop    = 1'b1;
      default:   f_start = 1'b1;
    endcase
    @(posedge clk); #1;
    start   = 1'b0;
    pause   = 1'b0;
    stop    = 1'b0;
    f_start = 1'b0;
  endtask

  initial begin
    logic [15:0] s;
    logic [15:0] held;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    frame(16'h7777);

    // Sample capture with latency check
    ready = 1'b1;
    pulse(P_START);
    nxt_addr = '0;
    check("start_state", 32'(state), 32'd1);
    chk_lat = 1'b1;
    push_exp(16'hA5C3);
    send_bits(16'hA5C3, 16'hFFFF, 0, 31);
    push_exp(16'h1234);
    frame(16'h1234);
    for (int i = 0; i < 2; i++) begin
      s = 16'($urandom);
      push_exp(s);
      frame(s);
    end
    chk_lat = 1'b0;
    check("cap_last_addr", 32'(last_addr), 32'd3);
    check("cap_overflow", 32'(overflow), 32'd0);
    check("cap_all_written", 32'(exp_q.size()), 32'd0);

    // Backpressure and overflow
    pulse(P_STOP);
    pulse(P_START);
    nxt_addr = '0;
    check("bp_fresh_addr", 32'(wr_addr), 32'd0);
    ready = 1'b0;
    push_exp(16'h0001);
    frame(16'h0001);
    frame(16'h0002);
    frame(16'h0003);
    check("bp_valid", 32'(wr_valid), 32'd1);
    check("bp_addr", 32'(wr_addr), 32'd0);
    check("bp_data", 32'(wr_data), 32'h0001);
    check("bp_overflow", 32'(overflow), 32'd1);
    ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    push_exp(16'h0004);
    frame(16'h0004);
    check("bp_all_written", 32'(exp_q.size()), 32'd0);
    check("bp_last_addr", 32'(last_addr), 32'd1);

    // Start in the middle of a left word
    pulse(P_STOP);
    s = 16'($urandom);
    send_bits(s, 16'h5555, 0, 7);
    pulse(P_START);
    nxt_addr = '0;
    check("mid_overflow_clr", 32'(overflow), 32'd0);
    send_bits(s, 16'h5555, 8, 31);
    s = 16'($urandom);
    push_exp(s);
    frame(s);
    check("mid_all_written", 32'(exp_q.size()), 32'd0);
    check("mid_last_addr", 32'(last_addr), 32'd0);

    // Pause and resume
    pulse(P_STOP);
    pulse(P_START);
    nxt_addr = '0;
    for (int i = 0; i < 3; i++) begin
      s = 16'($urandom);
      push_exp(s);
      frame(s);
    end
    pulse(P_PAUSE);
    check("pause_state", 32'(state), 32'd2);
    for (int i = 0; i < 2; i++) begin
      frame(16'($urandom));
      check("pause_last_addr", 32'(last_addr), 32'd2);
      check("pause_no_valid", 32'(wr_valid), 32'd0);
    end
    pulse(P_START);
    check("resume_state", 32'(state), 32'd1);
    s = 16'($urandom);
    push_exp(s);
    frame(s);
    check("resume_all_written", 32'(exp_q.size()), 32'd0);
    check("resume_last_addr", 32'(last_addr), 32'd3);

    // Full at ADDR_MAX=3 on the second instance
    pulse(P_STOP);
    pulse(P_F_START);
    for (int i = 0; i < 6; i++) begin
      s = 16'($urandom);
      if (i < 4) f_q.push_back('{a: 20'(i), d: s});
      frame(s);
    end
    check("full_state", 32'(f_state), 32'd3);
    check("full_flag", 32'(f_full), 32'd1);
    check("full_last_addr", 32'(f_last), 32'd3);
    check("full_addr_nowrap", 32'(f_addr), 32'd3);
    check("full_no_valid", 32'(f_valid), 32'd0);
    check("full_all_written", 32'(f_q.size()), 32'd0);

    // Stop with a write pending
    pulse(P_START);
    nxt_addr = '0;
    ready = 1'b0;
    s = 16'($urandom);
    push_exp(s);
    frame(s);
    pulse(P_STOP);
    check("stop_state", 32'(state), 32'd3);
    check("stop_valid_held", 32'(wr_valid), 32'd1);
    ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("stop_valid_done", 32'(wr_valid), 32'd0);
    check("stop_all_written", 32'(exp_q.size()), 32'd0);
    check("stop_last_addr", 32'(last_addr), 32'd0);
    frame(16'($urandom));

    // Asynchronous reset mid-sample with a held write and overflow set
    pulse(P_START);
    nxt_addr = '0;
    for (int i = 0; i < 2; i++) begin
      s = 16'($urandom);
      push_exp(s);
      frame(s);
    end
    ready = 1'b0;
    held = 16'($urandom);
    frame(held);
    frame(16'($urandom));
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    check("pre_rst_addr", 32'(wr_addr), 32'd2);
    check("pre_rst_data", 32'(wr_data), 32'(held));
    send_bits(16'($urandom), 16'h0F0F, 0, 8);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(wr_valid), 32'd0);
    check("arst_addr", 32'(wr_addr), 32'd0);
    check("arst_data", 32'(wr_data), 32'd0);
    check("arst_last_addr", 32'(last_addr), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    check("arst_overflow", 32'(overflow), 32'd0);
    check("arst_f_state", 32'(f_state), 32'd0);
    check("arst_f_full", 32'(f_full), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    frame(16'($urandom));
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_valid", 32'(wr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Capture stage between the WM8731 codec ADC serial interface and the SRAM write port in the audio recorder datapath.
- Deserialises the I2S left channel (16-bit, MSB first) into parallel samples.
- Presents each sample with an incrementing SRAM word address on a valid/ready write handshake.
- Run control is start/pause/stop; the block reports recorded length, full and overflow status for the controller and the time display.

Parameters:
- DATA_W, 16, sample width in bits, equal to the SRAM word width.
- ADDR_W, 20, SRAM word address width.
- ADDR_MAX, 20'hFFFFF, last writable address; the write at this address ends recording.

Ports:
- i_clk  in  1  system clock (12 MHz codec clock domain)
- i_rst  in  1  asynchronous active-high reset
- i_start  in  1  one-cycle pulse: in IDLE/DONE start a fresh recording; in PAUSE resume
- i_pause  in  1  one-cycle pulse: pause recording
- i_stop  in  1  one-cycle pulse: stop recording
- i_aud_bclk  in  1  codec bit clock, asynchronous to i_clk
- i_aud_lrck  in  1  codec ADC LR clock; low = left channel
- i_aud_adcdat  in  1  codec ADC serial data
- o_wr_valid  out  1  write request valid
- i_wr_ready  in  1  SRAM side accepts the write this cycle
- o_wr_addr  out  ADDR_W  SRAM word address of the current write
- o_wr_data  out  DATA_W  sample to write
- o_last_addr  out  ADDR_W  address of the most recently accepted write (recorded length - 1)
- o_state  out  2  IDLE=0, REC=1, PAUSE=2, DONE=3
- o_full  out  1  ADDR_MAX has been written
- o_overflow  out  1  sticky: at least one sample was dropped

Behaviour:
- Reset (async, i_rst=1) forces: all outputs 0, state IDLE, synchronisers and shift register cleared. Reset applies at any point, including mid-sample or mid-handshake.
- Input capture:
  - i_aud_bclk, i_aud_lrck and i_aud_adcdat each pass through a 2-FF synchroniser of equal depth.
  - A BCLK rising edge is detected when the second stage is 1 and the third (edge) register is 0.
  - All capture logic acts only on detected rising edges.
- Frame alignment (I2S): an LRCK falling transition is sampled on edge N, meaning LRCK was 1 at the previous edge and is 0 now. Edge N+1 carries the MSB, and edges N+1..N+16 carry bits 15..0. The right channel is ignored.
- Completion latency: o_wr_data updates and o_wr_valid rises exactly 3 i_clk cycles after the pin-level BCLK rising edge that carries the LSB.
- Capture only runs in REC. Capture starts at the first LRCK falling transition after entering REC, so a partial frame is never captured.
- Handshake:
  - o_wr_valid, o_wr_addr and o_wr_data are held stable until the cycle with o_wr_valid & i_wr_ready.
  - On that cycle: o_last_addr <= o_wr_addr and o_wr_valid drops.
  - The next sample uses o_wr_addr+1; o_wr_addr increments the cycle after acceptance.
- Overflow: if a sample completes while o_wr_valid=1 and no acceptance happens that cycle, the new sample is dropped, the held sample is unchanged and o_overflow sets. Acceptance and completion in the same cycle is not an overflow; the new sample loads the following cycle.
- State machine (priority stop > pause > start when pulses coincide):
  - IDLE -i_start-> REC: o_wr_addr=0, o_last_addr=0, o_full=0, o_overflow=0.
  - REC -i_pause-> PAUSE: partial shift discarded; a pending write stays valid until accepted.
  - PAUSE -i_start-> REC: address is kept; capture realigns on the next LRCK fall.
  - REC/PAUSE -i_stop-> DONE: partial shift discarded; a pending write still completes its handshake in DONE.
  - REC, acceptance at ADDR_MAX -> DONE with o_full=1. The address does not wrap.
  - DONE -i_start-> REC: fresh recording, as from IDLE.
  - i_pause in IDLE/PAUSE/DONE and i_stop in IDLE/DONE are ignored.
- o_state reflects the registered state.

Decomposition:
- Shared package aud_pkg holds:
  - rec_state_e (IDLE, REC, PAUSE, DONE as 2-bit encoded)
  - AUD_DATA_W = 16 and SRAM_ADDR_W = 20
- Sub-module i2s_rx_deser: synchronisers, BCLK edge detect, LRCK alignment and 16-bit shift register. Input en; outputs o_sample[15:0] and a one-cycle o_sample_stb. Deasserting en clears the bit counter.
- aud_recorder holds the FSM, holding register, address counter and flags.

Test Plan:
- Sample capture: bench runs BCLK at 8 i_clk periods with a continuous 32-bit frame; after i_start, left=16'hA5C3 and right=16'hFFFF, i_wr_ready=1. Required: first write is addr 0, data A5C3; valid rises 3 cycles after the LSB edge; the next left sample 16'h1234 goes to addr 1.
- Backpressure: i_wr_ready=0 for 2 sample periods with left samples 0001, 0002, 0003. Required: valid held with addr 0, data 0001; o_overflow=1; after ready, addr 0 data 0001 is accepted, then the next completed sample 0004 goes to addr 1.
- Mid-stream start: i_start asserted mid-left-frame. Required: the partial frame is ignored and the first write is the next full left sample.
- Pause/resume: pause after 3 writes, then resume. Required: no writes while in PAUSE; the next write uses addr 3 and o_last_addr=2 throughout the pause.
- Full: ADDR_MAX=20'h00003 override with 6 samples. Required: writes to addr 0..3, then DONE, o_full=1, o_last_addr=3, no further o_wr_valid.
- Stop with pending write and reset: stop while valid=1 and ready=0; later raise ready. Required: the write completes in DONE. Separately, i_rst mid-sample clears all outputs to 0 and o_state to 0 asynchronously.
